// File: rtl/booth_mul_pkg.sv
// Booth radix-4 digit controls, partial-product sizing and the pipeline slice record.
// Shared by booth_r4_ppgen and booth_mul_pipe (whose flush port is enabled by BOOTH_MUL_FLUSH_EN).
package booth_mul_pkg;

    typedef struct packed {
        logic set0;   // digit is 0: row is all zeros before inversion
        logic x2;     // digit magnitude is 2: select multiplicand shifted left by one
        logic inv;    // digit is negative: invert row, +1 goes into the compensation row
    } booth_ctl_t;

    localparam booth_ctl_t BOOTH_ZERO = '{set0: 1'b1, x2: 1'b0, inv: 1'b0};
    localparam booth_ctl_t BOOTH_P1   = '{set0: 1'b0, x2: 1'b0, inv: 1'b0};
    localparam booth_ctl_t BOOTH_P2   = '{set0: 1'b0, x2: 1'b1, inv: 1'b0};
    localparam booth_ctl_t BOOTH_M1   = '{set0: 1'b0, x2: 1'b0, inv: 1'b1};
    localparam booth_ctl_t BOOTH_M2   = '{set0: 1'b0, x2: 1'b1, inv: 1'b1};

    localparam int TAG_W_MAX = 32;

    typedef struct packed {
        logic                 vld;
        logic [TAG_W_MAX-1:0] tag;
    } slice_t;

    function automatic int pp_count(input int width);
        return (width + 2) / 2;
    endfunction

    function automatic booth_ctl_t booth_enc(input logic [2:0] bits);
        booth_ctl_t ctl;
        case (bits)
            3'b001, 3'b010: ctl = BOOTH_P1;
            3'b011:         ctl = BOOTH_P2;
            3'b100:         ctl = BOOTH_M2;
            3'b101, 3'b110: ctl = BOOTH_M1;
            default:        ctl = BOOTH_ZERO;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/booth_r4_ppgen.sv
// Radix-4 Booth encoder: pp_count(WIDTH) partial-product rows plus one sign-compensation row.
// Purely combinational; rows are 2*WIDTH bits and sum (mod 2^(2*WIDTH)) to a*b.
module booth_r4_ppgen
    import booth_mul_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int NPP   = pp_count(WIDTH),
    localparam int PW    = 2 * WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             a_signed_i,
    input  logic             b_signed_i,
    output logic [PW-1:0]    rows_o [NPP+1]
);

    localparam int XW = WIDTH + 2;
    localparam int KW = WIDTH + 3;

    // Each row's sign bit is stored inverted; the -2^(KW-1) each inversion implies
    // is pre-summed here into one constant.
    function automatic logic [PW-1:0] comp_const();
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < NPP; i++) begin
            c = c - (PW'(1) << (KW - 1 + 2 * i));
        end
        return c;
    endfunction

    localparam logic [PW-1:0] COMP = comp_const();

    logic [XW-1:0] a_x;
    logic [XW:0]   b_w;
    logic [KW-1:0] a_k;

    assign a_x = {{2{a_signed_i & a_i[WIDTH-1]}}, a_i};
    assign b_w = {{2{b_signed_i & b_i[WIDTH-1]}}, b_i, 1'b0};
    assign a_k = {a_x[XW-1], a_x};

    always_comb begin
        booth_ctl_t    ctl;
        logic [KW-1:0] sel;
        logic [KW-1:0] pp;
        logic [PW-1:0] inv_bits;
        ctl      = BOOTH_ZERO;
        sel      = '0;
        pp       = '0;
        inv_bits = '0;
        for (int i = 0; i < NPP; i++) begin
            ctl         = booth_enc(b_w[2*i +: 3]);
            sel         = ctl.set0 ? '0 : (ctl.x2 ? {a_k[KW-2:0], 1'b0} : a_k);
            pp          = ctl.inv ? ~sel : sel;
            rows_o[i]   = PW'({~pp[KW-1], pp[KW-2:0]}) << (2 * i);
            inv_bits[2*i] = ctl.inv;
        end
        rows_o[NPP] = COMP | inv_bits;
    end

endmodule

// File: rtl/booth_mul_pipe.sv
// Pipelined radix-4 Booth multiplier, STAGES cycles accept-to-result; flush port exists only with BOOTH_MUL_FLUSH_EN.
// Valid/ready: slices advance when downstream is empty or moving; a full stalled pipe holds in_ready low.
module booth_mul_pipe
    import booth_mul_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
`ifdef BOOTH_MUL_FLUSH_EN
    input  logic               flush,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               a_signed,
    input  logic               b_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int PW      = 2 * WIDTH;
    localparam int NROWS   = pp_count(WIDTH) + 1;
    localparam int REG_PP  = (STAGES >= 3) ? 1 : 0;
    localparam int REG_CS  = (STAGES >= 2) ? 1 : 0;
    localparam int NPROD   = STAGES - REG_PP - REG_CS;
    localparam int TREE_LV = 10;

    slice_t            slc_q [STAGES];
    logic [STAGES:0]   ld;

    // ld[k]: slice k loads this edge (empty, or its content moves on).
    always_comb begin
        ld         = '0;
        ld[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = !slc_q[k].vld || ld[k+1];
        end
    end

`ifdef BOOTH_MUL_FLUSH_EN
    assign in_ready = ld[0] && !flush;
`else
    assign in_ready = ld[0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                slc_q[k] <= '0;
            end
        end else begin
            if (ld[0]) begin
                slc_q[0] <= '{vld: in_valid && in_ready, tag: TAG_W_MAX'(in_tag)};
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) begin
                    slc_q[k] <= slc_q[k-1];
                end
            end
`ifdef BOOTH_MUL_FLUSH_EN
            if (flush) begin
                for (int k = 0; k < STAGES; k++) begin
                    slc_q[k].vld <= 1'b0;
                end
            end
`endif
        end
    end

    assign out_valid = slc_q[STAGES-1].vld;
    assign out_tag   = slc_q[STAGES-1].tag[TAG_W-1:0];

    logic [PW-1:0] pp_d   [NROWS];
    logic [PW-1:0] pp_cur [NROWS];

    booth_r4_ppgen #(.WIDTH(WIDTH)) u_ppgen (
        .a_i        (a),
        .b_i        (b),
        .a_signed_i (a_signed),
        .b_signed_i (b_signed),
        .rows_o     (pp_d)
    );

    if (REG_PP == 1) begin : g_pp_q
        logic [PW-1:0] pp_q [NROWS];
        always_ff @(posedge clk) begin
            if (ld[0]) pp_q <= pp_d;
        end
        assign pp_cur = pp_q;
    end else begin : g_pp_c
        assign pp_cur = pp_d;
    end

    // Wallace tree: each level compresses disjoint row triples 3:2 and passes leftovers through.
    logic [PW-1:0] red_cur [NROWS+2];
    logic [PW-1:0] red_nxt [NROWS+2];
    logic [PW-1:0] cs_d    [2];
    logic [PW-1:0] cs_cur  [2];

    always_comb begin
        int n;
        int m;
        red_cur = '{default: '0};
        red_nxt = '{default: '0};
        n = NROWS;
        m = 0;
        for (int r = 0; r < NROWS; r++) begin
            red_cur[r] = pp_cur[r];
        end
        for (int lv = 0; lv < TREE_LV; lv++) begin
            if (n > 2) begin
                m = 0;
                for (int j = 0; j < NROWS; j += 3) begin
                    if (j + 2 < n) begin
                        red_nxt[m]   = red_cur[j] ^ red_cur[j+1] ^ red_cur[j+2];
                        red_nxt[m+1] = ((red_cur[j] & red_cur[j+1]) | (red_cur[j] & red_cur[j+2])
                                       | (red_cur[j+1] & red_cur[j+2])) << 1;
                        m = m + 2;
                    end else if (j < n) begin
                        red_nxt[m] = red_cur[j];
                        m = m + 1;
                        if (j + 1 < n) begin
                            red_nxt[m] = red_cur[j+1];
                            m = m + 1;
                        end
                    end
                end
                n = m;
                red_cur = red_nxt;
            end
        end
        cs_d[0] = red_cur[0];
        cs_d[1] = red_cur[1];
    end

    if (REG_CS == 1) begin : g_cs_q
        logic [PW-1:0] cs_q [2];
        always_ff @(posedge clk) begin
            if (ld[REG_PP]) cs_q <= cs_d;
        end
        assign cs_cur = cs_q;
    end else begin : g_cs_c
        assign cs_cur = cs_d;
    end

    logic [PW-1:0] sum_d;
    logic [PW-1:0] prod_q [NPROD];

    assign sum_d = cs_cur[0] + cs_cur[1];

    always_ff @(posedge clk) begin
        if (ld[REG_PP+REG_CS]) prod_q[0] <= sum_d;
        for (int j = 1; j < NPROD; j++) begin
            if (ld[REG_PP+REG_CS+j]) prod_q[j] <= prod_q[j-1];
        end
    end

    assign product = prod_q[NPROD-1];

endmodule
